// File: rtl/tinyqv_peripherals.sv
// tinyQV peripheral block: GPIO, 8N1 UART with RX FIFO/RTS, and an optional edge-triggered
// interrupt controller built only when TINYQV_PERI_IRQ_EN is defined.
module tinyqv_peripherals #(
  parameter int unsigned GPIO_OUT_W    = 2,
  parameter int unsigned GPIO_IN_W     = 8,
  parameter int unsigned NUM_IRQ       = 2,
  parameter int unsigned RX_FIFO_DEPTH = 4,
  parameter int unsigned CLK_HZ        = 66_000_000,
  parameter int unsigned BIT_RATE      = 115_200
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [27:0]           addr,
  input  logic [1:0]            write_n,
  input  logic [1:0]            read_n,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic                  data_ready,
  input  logic [GPIO_IN_W-1:0]  gpio_in,
  output logic [GPIO_OUT_W-1:0] gpio_out,
  input  logic [NUM_IRQ-1:0]    irq_in,
  output logic                  irq_out,
  input  logic                  uart_rxd,
  output logic                  uart_txd,
  output logic                  uart_rts
);

  localparam int unsigned DIV  = CLK_HZ / BIT_RATE;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = $clog2(DIV + 1);
  localparam int unsigned AW   = $clog2(RX_FIFO_DEPTH);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(RX_FIFO_DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  logic       wr, rd, sel;
  logic [4:0] off;
  logic       wr_gpio, wr_udata, rd_udata, rd_ustat;

  assign wr       = (write_n != 2'b11);
  assign rd       = (read_n != 2'b11);
  assign sel      = (addr[27:5] == 23'h40_0000);
  assign off      = addr[4:0];
  assign wr_gpio  = wr && sel && (off == 5'h00);
  assign wr_udata = wr && sel && (off == 5'h10);
  assign rd_udata = rd && sel && (off == 5'h10);
  assign rd_ustat = rd && sel && (off == 5'h14);

  assign data_ready = 1'b1;

  logic unused_ok;
  assign unused_ok = ^data_in[31:8];

  // ---------------- GPIO ----------------
  logic [GPIO_OUT_W-1:0] gpio_out_q;
  logic [GPIO_IN_W-1:0]  gpio_s1_q, gpio_s2_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gpio_out_q <= '0;
      gpio_s1_q  <= '0;
      gpio_s2_q  <= '0;
    end else begin
      gpio_s1_q <= gpio_in;
      gpio_s2_q <= gpio_s1_q;
      if (wr_gpio) gpio_out_q <= data_in[GPIO_OUT_W-1:0];
    end
  end

  assign gpio_out = gpio_out_q;

  // ---------------- UART TX ----------------
  logic          tx_pend_q, tx_busy_q;
  logic [9:0]    tx_shift_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_bit_q;

  // The write loads the frame; the line only drops when busy asserts one cycle later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_pend_q  <= 1'b0;
      tx_busy_q  <= 1'b0;
      tx_shift_q <= '1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
    end else if (tx_pend_q) begin
      tx_pend_q <= 1'b0;
      tx_busy_q <= 1'b1;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == DIV_LAST) begin
        tx_cnt_q <= '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_q <= 1'b0;
        end else begin
          tx_shift_q <= {1'b1, tx_shift_q[9:1]};
          tx_bit_q   <= tx_bit_q + 4'd1;
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end
    end else if (wr_udata) begin
      tx_pend_q  <= 1'b1;
      tx_shift_q <= {1'b1, data_in[7:0], 1'b0};
    end
  end

  assign uart_txd = tx_busy_q ? tx_shift_q[0] : 1'b1;

  // ---------------- UART RX ----------------
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sr_q, rx_sr_d;
  logic          rxd_s1_q, rxd_s2_q, rxd_s3_q;
  logic          push_req, frame_set;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sr_q    <= '0;
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_s3_q   <= 1'b1;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sr_q    <= rx_sr_d;
      rxd_s1_q   <= uart_rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_s3_q   <= rxd_s2_q;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_sr_d    = rx_sr_q;
    push_req   = 1'b0;
    frame_set  = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rxd_s3_q && !rxd_s2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d = '0;
          rx_sr_d  = {rxd_s2_q, rx_sr_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          push_req   = rxd_s2_q;
          frame_set  = !rxd_s2_q;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- RX FIFO and status flags ----------------
  logic [7:0]    fifo_mem [RX_FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          rx_valid, rx_full, pop, push, ovr_set;
  logic          ovr_q, frame_q;

  assign rx_valid = (count_q != '0);
  assign rx_full  = (count_q == FIFO_FULL);
  assign pop      = rd_udata && rx_valid;
  assign push     = push_req && (!rx_full || pop);
  assign ovr_set  = push_req && rx_full && !pop;
  assign uart_rts = rx_full;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q] <= rx_sr_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovr_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      ovr_q   <= ovr_set   | (ovr_q   & ~rd_ustat);
      frame_q <= frame_set | (frame_q & ~rd_ustat);
    end
  end

  // ---------------- Interrupt controller ----------------
`ifdef TINYQV_PERI_IRQ_EN
  logic [NUM_IRQ-1:0] irq_s1_q, irq_s2_q, irq_s3_q, irq_sts_q, irq_rise, irq_clr;
  logic [NUM_IRQ:0]   irq_en_q, irq_all;
  logic               irq_out_q, wr_ists, wr_ien;

  assign wr_ists  = wr && sel && (off == 5'h08);
  assign wr_ien   = wr && sel && (off == 5'h0C);
  assign irq_rise = irq_s2_q & ~irq_s3_q;
  assign irq_clr  = wr_ists ? data_in[NUM_IRQ-1:0] : '0;
  assign irq_all  = {rx_valid, irq_sts_q};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_s1_q  <= '0;
      irq_s2_q  <= '0;
      irq_s3_q  <= '0;
      irq_sts_q <= '0;
      irq_en_q  <= '0;
      irq_out_q <= 1'b0;
    end else begin
      irq_s1_q  <= irq_in;
      irq_s2_q  <= irq_s1_q;
      irq_s3_q  <= irq_s2_q;
      irq_sts_q <= irq_rise | (irq_sts_q & ~irq_clr);
      if (wr_ien) irq_en_q <= data_in[NUM_IRQ:0];
      irq_out_q <= |(irq_all & irq_en_q);
    end
  end

  assign irq_out = irq_out_q;
`else
  logic unused_irq;
  assign unused_irq = ^irq_in;
  assign irq_out    = 1'b0;
`endif

  // ---------------- Read mux ----------------
  always_comb begin
    data_out = '1;
    if (sel) begin
      case (off)
        5'h00: data_out = 32'(gpio_out_q);
        5'h04: data_out = 32'(gpio_s2_q);
`ifdef TINYQV_PERI_IRQ_EN
        5'h08: data_out = 32'(irq_all);
        5'h0C: data_out = 32'(irq_en_q);
`endif
        5'h10: data_out = rx_valid ? {24'h0, fifo_mem[rptr_q]} : '0;
        5'h14: data_out = {27'h0, frame_q, ovr_q, rx_full, rx_valid, tx_busy_q};
        default: ;
      endcase
    end
  end

endmodule
